// File: rtl/imem_loader_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_loader_pkg                                                  |
// | Brief   : Shared constants for the serial imem loader and its UART front.  |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
package imem_loader_pkg;

    localparam logic [7:0] c_sync_byte = 8'h55;

    // Framing FSM encodings
    localparam int         c_st_w    = 3;
    localparam logic [2:0] c_st_idle = 3'd0;
    localparam logic [2:0] c_st_cnth = 3'd1;
    localparam logic [2:0] c_st_cntl = 3'd2;
    localparam logic [2:0] c_st_data = 3'd3;
    localparam logic [2:0] c_st_csum = 3'd4;
    localparam logic [2:0] c_st_done = 3'd5;
    localparam logic [2:0] c_st_err  = 3'd6;

    // UART receiver encodings
    localparam logic [1:0] c_rx_idle  = 2'd0;
    localparam logic [1:0] c_rx_start = 2'd1;
    localparam logic [1:0] c_rx_data  = 2'd2;
    localparam logic [1:0] c_rx_stop  = 2'd3;

    function automatic logic in_frame(input logic [2:0] st);
        return (st == c_st_cnth) || (st == c_st_cntl) ||
               (st == c_st_data) || (st == c_st_csum);
    endfunction

endpackage
`default_nettype wire

// File: rtl/imem_loader_uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_loader_uart_rx                                              |
// | Brief   : 8N1 receiver: 2-flop synchroniser, bit timer, LSB-first shifter. |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module imem_loader_uart_rx
    import imem_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rxd,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frame_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT + 1);

    logic [1:0]         r_sync;
    logic               r_rx_d;
    logic [1:0]         r_state;
    logic [1:0]         w_next;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;

    logic w_rx;
    logic w_fall;
    logic w_tick_half;
    logic w_tick_full;
    logic w_stop_tick;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_rx_d & ~w_rx;
    assign w_tick_half = (r_cnt == c_cnt_w'(CLKS_PER_BIT / 2 - 1));
    assign w_tick_full = (r_cnt == c_cnt_w'(CLKS_PER_BIT - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_rx_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_rx_idle:  if (w_fall) w_next = c_rx_start;
            // A start bit that is high again at mid-bit was a glitch
            c_rx_start: if (w_tick_half) w_next = w_rx ? c_rx_idle : c_rx_data;
            c_rx_data:  if (w_tick_full && (r_bit == 3'd7)) w_next = c_rx_stop;
            c_rx_stop:  if (w_tick_full) w_next = c_rx_idle;
            default:    w_next = c_rx_idle;
        endcase
    end

    assign w_stop_tick = (r_state == c_rx_stop) && w_tick_full;

    always_comb begin
        o_byte      = r_shift;
        o_byte_vld  = w_stop_tick & w_rx;
        o_frame_err = w_stop_tick & ~w_rx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= 2'b11;
            r_rx_d  <= 1'b1;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
        end else begin
            r_sync <= {r_sync[0], i_rxd};
            r_rx_d <= w_rx;
            if ((r_state == c_rx_idle) || (w_next != r_state) || w_tick_full) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == c_rx_start) begin
                r_bit <= '0;
            end else if ((r_state == c_rx_data) && w_tick_full) begin
                r_shift <= {w_rx, r_shift[7:1]};
                r_bit   <= r_bit + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : imem_loader                                                      |
// | Brief   : Framed UART program loader writing imem; holds CPU in reset.     |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int CLK_HZ     = 16_000_000,
    parameter int BAUD       = 1_000_000,
    parameter int ADDR_WIDTH = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rxd,
    output logic [31:0] ld_addr,
    output logic [31:0] ld_data,
    output logic        ld_we,
    output logic        cpu_rst,
    output logic        busy,
    output logic        done,
    output logic        err
);

    localparam int          c_clks_per_bit = CLK_HZ / BAUD;
    localparam logic [15:0] c_max_words    = 16'(1 << ADDR_WIDTH);

    logic [7:0]          w_byte;
    logic                w_byte_vld;
    logic                w_frame_err;
    logic [c_st_w-1:0]   r_state;
    logic [c_st_w-1:0]   w_next;
    logic [7:0]          r_cnt_hi;
    logic [15:0]         r_count;
    logic [15:0]         w_count_in;
    logic [7:0]          r_sum;
    logic [1:0]          r_byte_idx;
    logic [ADDR_WIDTH:0] r_word_idx;
    logic [ADDR_WIDTH:0] w_word_next;
    logic                w_last;
    logic [23:0]         r_asm;
    logic [ADDR_WIDTH-1:0] r_ld_addr;
    logic [31:0]         r_ld_data;
    logic                r_ld_we;

    imem_loader_uart_rx #(
        .CLKS_PER_BIT (c_clks_per_bit)
    ) u_uart_rx (
        .clk         (clk),
        .rst         (rst),
        .i_rxd       (rxd),
        .o_byte      (w_byte),
        .o_byte_vld  (w_byte_vld),
        .o_frame_err (w_frame_err)
    );

    assign w_count_in  = {r_cnt_hi, w_byte};
    assign w_word_next = r_word_idx + 1'b1;
    assign w_last      = ({{(15 - ADDR_WIDTH){1'b0}}, w_word_next} == r_count);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        if (w_frame_err && in_frame(r_state)) begin
            w_next = c_st_err;
        end else if (w_byte_vld) begin
            case (r_state)
                c_st_idle, c_st_done: if (w_byte == c_sync_byte) w_next = c_st_cnth;
                c_st_cnth: w_next = c_st_cntl;
                c_st_cntl: begin
                    if (w_count_in == 16'd0)              w_next = c_st_csum;
                    else if (w_count_in > c_max_words)    w_next = c_st_err;
                    else                                  w_next = c_st_data;
                end
                c_st_data: if ((r_byte_idx == 2'd3) && w_last) w_next = c_st_csum;
                c_st_csum: w_next = (w_byte == r_sum) ? c_st_done : c_st_err;
                default:   w_next = r_state;
            endcase
        end
    end

    always_comb begin
        busy    = in_frame(r_state);
        done    = (r_state == c_st_done);
        err     = (r_state == c_st_err);
        cpu_rst = (r_state != c_st_done) | rst;
        ld_addr = {{(32 - ADDR_WIDTH){1'b0}}, r_ld_addr};
        ld_data = r_ld_data;
        ld_we   = r_ld_we;
    end

    // Word assembly keeps ld_data stable between writes
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt_hi   <= '0;
            r_count    <= '0;
            r_sum      <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_asm      <= '0;
            r_ld_addr  <= '0;
            r_ld_data  <= '0;
            r_ld_we    <= 1'b0;
        end else begin
            r_ld_we <= 1'b0;
            if (w_byte_vld) begin
                case (r_state)
                    c_st_idle, c_st_done: begin
                        if (w_byte == c_sync_byte) begin
                            r_sum      <= '0;
                            r_byte_idx <= '0;
                            r_word_idx <= '0;
                        end
                    end
                    c_st_cnth: r_cnt_hi <= w_byte;
                    c_st_cntl: r_count  <= w_count_in;
                    c_st_data: begin
                        r_sum      <= r_sum + w_byte;
                        r_byte_idx <= r_byte_idx + 1'b1;
                        case (r_byte_idx)
                            2'd0: r_asm[7:0]   <= w_byte;
                            2'd1: r_asm[15:8]  <= w_byte;
                            2'd2: r_asm[23:16] <= w_byte;
                            default: begin
                                r_ld_data  <= {w_byte, r_asm};
                                r_ld_addr  <= r_word_idx[ADDR_WIDTH-1:0];
                                r_ld_we    <= 1'b1;
                                r_word_idx <= w_word_next;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_imem_loader                                                   |
// | Brief   : Directed self-checking bench for imem_loader at 16 clk/bit.      |
// | Rev     : 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        rxd;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;
    logic        ld_we;
    logic        cpu_rst;
    logic        busy;
    logic        done;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    imem_loader #(
        .CLK_HZ     (16_000_000),
        .BAUD       (1_000_000),
        .ADDR_WIDTH (12)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .rxd     (rxd),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .ld_we   (ld_we),
        .cpu_rst (cpu_rst),
        .busy    (busy),
        .done    (done),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ld_we) begin
            wr_addr_q.push_back(ld_addr);
            wr_data_q.push_back(ld_data);
        end
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    // probe: 1 = single-cycle ld_we, 2 = done rise, 3 = reload drop of done
    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int probe);
        logic [7:0] v;
        v = b;
        rxd = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = v[i];
            repeat (16) @(negedge clk);
        end
        rxd = stop_bit;
        repeat (10) @(negedge clk);
        if (probe == 1) check("we_before", {63'd0, ld_we}, 64'd0);
        if (probe == 2) check("done_before", {62'd0, done, cpu_rst}, 64'b01);
        if (probe == 3) check("reload_before", {62'd0, done, cpu_rst}, 64'b10);
        @(negedge clk);
        if (probe == 1) check("we_pulse", {63'd0, ld_we}, 64'd1);
        if (probe == 2) check("done_rise", {62'd0, done, cpu_rst}, 64'b10);
        if (probe == 3) check("reload_drop", {62'd0, done, cpu_rst}, 64'b01);
        @(negedge clk);
        if (probe == 1) check("we_end", {63'd0, ld_we}, 64'd0);
        repeat (4) @(negedge clk);
        rxd = 1'b1;
    endtask

    task automatic do_reset();
        rxd = 1'b1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
    endtask

    task automatic send_frame1(input logic [7:0] csum, input int csum_probe);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'h08, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h20, 1'b1, 1);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 1);
        send_byte(csum, 1'b1, csum_probe);
    endtask

    task automatic check_two_writes(input string tag);
        check({tag, "_nwr"}, 64'(wr_addr_q.size()), 64'd2);
        if (wr_addr_q.size() >= 2) begin
            check({tag, "_w0"}, {wr_addr_q[0], wr_data_q[0]}, {32'd0, 32'h2000083C});
            check({tag, "_w1"}, {wr_addr_q[1], wr_data_q[1]}, {32'd1, 32'h00000000});
        end
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_addr_data", {ld_addr, ld_data}, 64'd0);
        check("rst_flags", {59'd0, ld_we, cpu_rst, busy, done, err}, {59'd0, 5'b01000});
        rst = 1'b0;
        idle(4);

        // 1: good two-word frame
        send_byte(8'h55, 1'b1, 0);
        check("t1_busy", {61'd0, busy, cpu_rst, done}, {61'd0, 3'b110});
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'h08, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h20, 1'b1, 1);
        check("t1_hold", {ld_addr, ld_data}, {32'd0, 32'h2000083C});
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 1);
        send_byte(8'h64, 1'b1, 2);
        check_two_writes("t1");
        check("t1_final", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b0010});

        // 2: bad checksum
        do_reset();
        send_frame1(8'h65, 0);
        check_two_writes("t2");
        check("t2_final", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1001});

        // 3: junk before sync, empty image
        do_reset();
        send_byte(8'hA5, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        check("t3_ignored", {63'd0, busy}, 64'd0);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h00, 1'b1, 2);
        check("t3_nwr", 64'(wr_addr_q.size()), 64'd0);
        check("t3_final", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b0010});

        // 4: count limits
        do_reset();
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h10, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        check("t4_over", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1001});
        check("t4_over_nwr", 64'(wr_addr_q.size()), 64'd0);
        do_reset();
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h10, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        check("t4_max", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1100});
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h03, 1'b1, 0);
        send_byte(8'h04, 1'b1, 1);
        check("t4_max_nwr", 64'(wr_addr_q.size()), 64'd1);
        if (wr_addr_q.size() >= 1)
            check("t4_max_w0", {wr_addr_q[0], wr_data_q[0]}, {32'd0, 32'h04030201});
        check("t4_max_busy", {63'd0, busy}, 64'd1);

        // 5: start-bit glitch, framing errors
        do_reset();
        rxd = 1'b0;
        repeat (8) @(negedge clk);
        idle(24);
        send_byte(8'h55, 1'b1, 0);
        check("t5_glitch", {63'd0, busy}, 64'd1);
        do_reset();
        send_byte(8'h55, 1'b0, 0);
        idle(16);
        check("t5_idle_ferr", {62'd0, busy, err}, 64'd0);
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h01, 1'b1, 0);
        send_byte(8'h11, 1'b0, 0);
        idle(16);
        check("t5_data_ferr", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1001});

        // 6: reset mid-frame, resend, reload
        do_reset();
        send_byte(8'h55, 1'b1, 0);
        send_byte(8'h00, 1'b1, 0);
        send_byte(8'h02, 1'b1, 0);
        send_byte(8'h3C, 1'b1, 0);
        send_byte(8'h08, 1'b1, 0);
        check("t6_pre", {63'd0, busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("t6_rst", {ld_addr, ld_data[30:0], ld_we}, 64'd0);
        check("t6_rst_flags", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1000});
        rst = 1'b0;
        repeat (2) @(negedge clk);
        wr_addr_q.delete();
        wr_data_q.delete();
        send_frame1(8'h64, 2);
        check_two_writes("t6");
        send_byte(8'h55, 1'b1, 3);
        check("t6_reload", {60'd0, cpu_rst, busy, done, err}, {60'd0, 4'b1100});

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
